serial_to_parallel_hs: RTL
==========================

# serial_to_parallel_hs

Parametrised serial-to-parallel deserializer with a valid/accept output handshake, selectable bit order, frame indexing and overflow detection. Sits between a single-bit serial receive front end and a byte/word consumer. The consumer may stall; words completed while it stalls are dropped and flagged.

## Interface
Parameters:
- DATA_W, 8: word width in bits, legal 2..32.
- IDX_W, 8: width of frame index counter.
- LSB_FIRST, 1: 1 = first serial bit lands in ParallelData[0]; 0 = first bit lands in ParallelData[DATA_W-1].

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock, all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- Enable  in  1  DataIn valid this cycle.
- DataIn  in  1  serial data bit.
- Accept  in  1  consumer takes the held word this cycle (when Ready=1).
- ClearOvf  in  1  clears Overflow.
- Ready  out  1  ParallelData holds a valid word.
- ParallelData  out  DATA_W  assembled word; forced to 0 when Ready=0.
- Index  out  IDX_W  index of the word currently/last presented.
- BitCount  out  $clog2(DATA_W+1)  bits collected in current partial word.
- Overflow  out  1  sticky: a completed word was dropped.

## Operation
- Reset (RST=1 at an edge): state=IDLE, shift register=0, BitCount=0, Ready=0, held word=0, Index=0, Overflow=0. Reset mid-word discards the partial word and any held word.
- States: IDLE (no partial word), SHIFT (1..DATA_W-1 bits collected).
- IDLE: Enable=1 → sample DataIn as bit 0 of word, BitCount=1, go SHIFT. Enable=0 → stay.
- SHIFT: Enable=1 → sample next bit, BitCount+1. Enable=0 → partial word discarded, shift register and BitCount cleared, go IDLE (matches existing deserializer abort behaviour).
- Word completion: the edge sampling bit DATA_W-1 completes the word; BitCount returns to 0, state returns to IDLE (so a continuous Enable stream yields back-to-back words with no gap).
- Bit placement: bit k of the serial stream goes to position k (LSB_FIRST=1) or DATA_W-1-k (LSB_FIRST=0).
- Output register: completed word is loaded if Ready=0, or if Ready=1 and Accept=1 on the same edge. Load sets Ready=1 and Index=Index+1 (mod 2^IDX_W). First word after reset presents Index=1.
- Ready=1, Accept=1, no completion → Ready=0, ParallelData=0, Index unchanged.
- Overflow: completion with Ready=1 and Accept=0 → new word dropped, held word and Index unchanged, Overflow=1. Overflow cleared only by ClearOvf or RST; if ClearOvf and a new drop coincide, Overflow=1.
- Accept while Ready=0 is ignored.

## Timing
- Latency: Ready rises on the edge that samples the last bit (visible the following cycle); DATA_W cycles from first Enabled bit.
- Sustained throughput: one word per DATA_W cycles with Accept held high; no drops.
- Consumer has DATA_W-1 cycles of slack after Ready rises before the next completion would drop.
- All outputs registered except ParallelData zero-gating (combinational AND with Ready).
- Index wraps 2^IDX_W-1 → 0 with no side effect.

## Structure
- Shared package: state encoding (IDLE, SHIFT) and a bit-position function pos(k, LSB_FIRST, DATA_W).
- One natural sub-module: output_hold_reg (word register + Ready/Accept/Overflow/Index logic); shift/count FSM stays in the top.

## Test plan
- DATA_W=8, LSB_FIRST=1, stream bits 1,0,1,0,0,0,0,1 with Accept=1 → Ready high one cycle after 8th bit, ParallelData=8'h85, Index=1.
- Same bits with LSB_FIRST=0 → ParallelData=8'hA1; three back-to-back words with Accept high → Index 1,2,3, no Overflow, no idle gap.
- Enable drops after 5 bits, then 8 bits of 0xFF → discarded partial, ParallelData=8'hFF, BitCount reset to 0 at drop.
- Hold Accept=0 over two complete words 0x11, 0x22 → ParallelData stays 0x11, Index=1, Overflow=1; ClearOvf pulse → Overflow=0.
- Accept=1 on exact edge of next completion → new word loaded, Ready stays 1, Overflow stays 0; ClearOvf coincident with drop → Overflow=1.
- RST asserted mid-word and with Ready=1 → next cycle Ready=0, ParallelData=0, Index=0, BitCount=0; IDX_W=2 run of 5 words → Index 1,2,3,0,1.

Source files
------------

// File: rtl/serial_to_parallel_hs_pkg.sv
// serial_to_parallel_hs_pkg: shared state encoding and serial-bit placement helper
package serial_to_parallel_hs_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;
  function automatic int pos(input int k, input bit lsb_first, input int data_w);
    return lsb_first ? k : data_w - 1 - k;
  endfunction
endpackage

// File: rtl/serial_to_parallel_hs_output_hold_reg.sv
// serial_to_parallel_hs_output_hold_reg: holds completed words for the consumer, tracks index and drops
module serial_to_parallel_hs_output_hold_reg #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              accept_i,
  input  logic              clear_ovf_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic [IDX_W-1:0]  index_o,
  output logic              overflow_o
);
  logic              ready_q;
  logic [DATA_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ovf_q;
  logic              load, drop;
  assign load = done_i && (!ready_q || accept_i);
  assign drop = done_i && ready_q && !accept_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      word_q  <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (load) begin
        ready_q <= 1'b1;
        word_q  <= word_i;
        idx_q   <= idx_q + 1'b1;
      end else if (ready_q && accept_i) begin
        ready_q <= 1'b0;
        word_q  <= '0;
      end
      ovf_q <= drop || (ovf_q && !clear_ovf_i);
    end
  end
  assign ready_o    = ready_q;
  assign data_o     = word_q & {DATA_W{ready_q}};
  assign index_o    = idx_q;
  assign overflow_o = ovf_q;
endmodule

// File: rtl/serial_to_parallel_hs.sv
// serial_to_parallel_hs: serial-to-parallel deserializer with valid/accept output handshake
module serial_to_parallel_hs
  import serial_to_parallel_hs_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int IDX_W     = 8,
  parameter int LSB_FIRST = 1,
  localparam int CNT_W    = $clog2(DATA_W + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Enable,
  input  logic              DataIn,
  input  logic              Accept,
  input  logic              ClearOvf,
  output logic              Ready,
  output logic [DATA_W-1:0] ParallelData,
  output logic [IDX_W-1:0]  Index,
  output logic [CNT_W-1:0]  BitCount,
  output logic              Overflow
);
  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sreg_q;
  logic [DATA_W-1:0] word_d;
  logic              last;
  assign last   = Enable && cnt_q == CNT_W'(DATA_W - 1);
  // IDLE always starts a fresh word at serial bit 0
  assign word_d = (state_q == SHIFT ? sreg_q : '0)
                | (DATA_W'(DataIn) << pos(state_q == SHIFT ? int'(cnt_q) : 0, LSB_FIRST != 0, DATA_W));
  always_ff @(posedge CLK) begin
    if (RST || !Enable || last) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
    end else begin
      state_q <= SHIFT;
      cnt_q   <= cnt_q + 1'b1;
      sreg_q  <= word_d;
    end
  end
  assign BitCount = cnt_q;
  serial_to_parallel_hs_output_hold_reg #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_hold (
    .clk        (CLK),
    .rst        (RST),
    .done_i     (last),
    .word_i     (word_d),
    .accept_i   (Accept),
    .clear_ovf_i(ClearOvf),
    .ready_o    (Ready),
    .data_o     (ParallelData),
    .index_o    (Index),
    .overflow_o (Overflow)
  );
endmodule
